// File: rtl/barrelshifter_pkg.sv
// Shared mode encodings and per-stage control payload for the pipelined barrel shifter.
// Optional carry tracking is enabled by defining BARRELSHIFTER_CARRY_OUT_EN.
package barrelshifter_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  // Control fields that travel with each beat; data and sa widths follow the top parameter.
  typedef struct packed {
    logic       left;
    logic [1:0] mode;
`ifdef BARRELSHIFTER_CARRY_OUT_EN
    logic       carry;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/barrelshifter_stage.sv
// One pipeline stage: conditional shift by SHIFT, payload register and valid/advance control.
// Carry capture is present only when BARRELSHIFTER_CARRY_OUT_EN is defined.
module barrelshifter_stage
  import barrelshifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SA_W  = 4,
  parameter int unsigned SHIFT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SA_W-1:0]  in_sa,
  input  stage_ctl_t       in_ctl,
  input  logic             next_adv,
  output logic             adv_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SA_W-1:0]  out_sa,
  output stage_ctl_t       out_ctl
);

  localparam int unsigned SA_BIT = $clog2(SHIFT);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SA_W-1:0]  sa_q, sa_d;
  stage_ctl_t       ctl_q, ctl_d;
  logic [WIDTH-1:0] shifted;

  assign adv_c = !valid_q || next_adv;

  // Shift mux; arithmetic right stays correct stage by stage since the MSB is preserved.
  always_comb begin
    shifted = in_data;
    if (in_sa[SA_BIT]) begin
      if (in_ctl.mode == MODE_ROT) begin
        shifted = in_ctl.left ? {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1 -: SHIFT]}
                              : {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
      end else if (in_ctl.left) begin
        shifted = in_data << SHIFT;
      end else if (in_ctl.mode == MODE_ARITH) begin
        shifted = WIDTH'($signed(in_data) >>> SHIFT);
      end else begin
        shifted = in_data >> SHIFT;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sa_d    = sa_q;
    ctl_d   = ctl_q;
    if (adv_c) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = shifted;
        sa_d   = in_sa;
        ctl_d  = in_ctl;
`ifdef BARRELSHIFTER_CARRY_OUT_EN
        // The last shifting stage sees the final bit to leave; rotate lands it at the wrap end.
        if (in_sa[SA_BIT]) begin
          ctl_d.carry = in_ctl.left ? in_data[WIDTH-SHIFT] : in_data[SHIFT-1];
        end
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sa_q    <= '0;
      ctl_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sa_q    <= sa_d;
      ctl_q   <= ctl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sa    = sa_q;
  assign out_ctl   = ctl_q;

endmodule

// File: rtl/barrelshifter_pipe.sv
// Pipelined barrel shifter, one registered stage per shift-amount bit, valid/ready on both ends.
// Define BARRELSHIFTER_CARRY_OUT_EN to add the carry_out port.
module barrelshifter_pipe
  import barrelshifter_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SA_W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SA_W-1:0]  in_sa,
  input  logic             in_left,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARRELSHIFTER_CARRY_OUT_EN
  ,
  output logic             carry_out
`endif
);

  logic             valid_p [SA_W+1];
  logic [WIDTH-1:0] data_p  [SA_W+1];
  logic [SA_W-1:0]  sa_p    [SA_W+1];
  stage_ctl_t       ctl_p   [SA_W+1];
  logic             adv_p   [SA_W+1];
  stage_ctl_t       in_ctl;

  // Reserved mode collapses to logical at entry so stages only see three encodings.
  always_comb begin
    in_ctl      = '0;
    in_ctl.left = in_left;
    in_ctl.mode = (in_mode == MODE_ARITH || in_mode == MODE_ROT) ? in_mode : MODE_LOGIC;
  end

  assign valid_p[0]  = in_valid;
  assign data_p[0]   = in_data;
  assign sa_p[0]     = in_sa;
  assign ctl_p[0]    = in_ctl;
  assign adv_p[SA_W] = out_ready;

  for (genvar k = 0; k < SA_W; k++) begin : g_stage
    barrelshifter_stage #(
      .WIDTH (WIDTH),
      .SA_W  (SA_W),
      .SHIFT (1 << k)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (valid_p[k]),
      .in_data   (data_p[k]),
      .in_sa     (sa_p[k]),
      .in_ctl    (ctl_p[k]),
      .next_adv  (adv_p[k+1]),
      .adv_c     (adv_p[k]),
      .out_valid (valid_p[k+1]),
      .out_data  (data_p[k+1]),
      .out_sa    (sa_p[k+1]),
      .out_ctl   (ctl_p[k+1])
    );
  end

  assign in_ready  = adv_p[0];
  assign out_valid = valid_p[SA_W];
  assign out_data  = data_p[SA_W];
`ifdef BARRELSHIFTER_CARRY_OUT_EN
  assign carry_out = ctl_p[SA_W].carry;
`endif

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Self-checking bench for barrelshifter_pipe at WIDTH=8: directed table, sweep, backpressure,
// random traffic against an arithmetic reference model, and asynchronous reset mid-stream.
module tb_barrelshifter_pipe;

  localparam int unsigned W = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sa;
  logic       in_left;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef BARRELSHIFTER_CARRY_OUT_EN
  logic       carry_out;
`endif

  barrelshifter_pipe #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sa     (in_sa),
    .in_left   (in_left),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARRELSHIFTER_CARRY_OUT_EN
    ,
    .carry_out (carry_out)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic [2:0] sa;
    logic       left;
    logic [1:0] mode;
    logic [7:0] exp;
    logic       expc;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       c;
  } res_t;

  int         total = 0;
  int         bad = 0;
  res_t       expq[$];
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shifts as multiply/divide by 2^n, rotates as two shifted halves OR'd.
  function automatic logic [7:0] ref_out(input logic [7:0] d, input int n, input bit left,
                                         input logic [1:0] mode);
    int unsigned v = d;
    int unsigned p = 1 << n;
    int unsigned r;
    if (mode == 2'b10) r = left ? ((v * p) | (v >> (8 - n))) : ((v >> n) | (v << (8 - n)));
    else if (left) r = v * p;
    else if (mode == 2'b01 && d[7]) r = (v / p) + (256 - 256 / p);
    else r = v / p;
    return 8'(r & 255);
  endfunction

  function automatic logic ref_carry(input logic [7:0] d, input int n, input bit left);
    if (n == 0) return 1'b0;
    return left ? d[8-n] : d[n-1];
  endfunction

  // Scoreboard: records accepts, checks drains in order, checks hold under stall.
  always begin
    res_t r;
    @(negedge clock);
    #2;
    if (mon_en) begin
      if (prev_stall) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          r = expq.pop_front();
          check("out_data", 32'(out_data), 32'(r.d));
`ifdef BARRELSHIFTER_CARRY_OUT_EN
          check("carry_out", 32'(carry_out), 32'(r.c));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        r.d = ref_out(in_data, int'(in_sa), in_left, in_mode);
        r.c = ref_carry(in_data, int'(in_sa), in_left);
        expq.push_back(r);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive(input logic [7:0] d, input logic [2:0] sa, input logic left,
                       input logic [1:0] mode);
    in_data = d;
    in_sa   = sa;
    in_left = left;
    in_mode = mode;
  endtask

  // Latency is counted in cycles from the cycle the beat is offered on an empty pipe.
  task automatic single_beat(input logic [7:0] d, input logic [2:0] sa, input logic left,
                             input logic [1:0] mode, output logic [7:0] res, output logic c,
                             output int lat);
    @(negedge clock);
    drive(d, sa, left, mode);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    res = out_data;
`ifdef BARRELSHIFTER_CARRY_OUT_EN
    c = carry_out;
`else
    c = 1'b0;
`endif
  endtask

  initial begin
    vec_t       vecs[12];
    logic [7:0] res;
    logic       c;
    int         lat;
    int         stalls;
    int         idx;
    int         acc_cyc[5];
    logic [7:0] bp_d[5];
    int         n_acc;
    bit         have;

    vecs[0]  = '{8'hB1, 3'd3, 1'b0, 2'b00, 8'h16, 1'b0};
    vecs[1]  = '{8'hB1, 3'd3, 1'b0, 2'b01, 8'hF6, 1'b0};
    vecs[2]  = '{8'h31, 3'd3, 1'b0, 2'b01, 8'h06, 1'b0};
    vecs[3]  = '{8'hB1, 3'd3, 1'b1, 2'b10, 8'h8D, 1'b1};
    vecs[4]  = '{8'hB1, 3'd3, 1'b0, 2'b10, 8'h36, 1'b0};
    vecs[5]  = '{8'hB1, 3'd3, 1'b1, 2'b00, 8'h88, 1'b1};
    vecs[6]  = '{8'hB1, 3'd3, 1'b0, 2'b11, 8'h16, 1'b0};
    vecs[7]  = '{8'hB1, 3'd0, 1'b0, 2'b01, 8'hB1, 1'b0};
    vecs[8]  = '{8'hB1, 3'd0, 1'b1, 2'b10, 8'hB1, 1'b0};
    vecs[9]  = '{8'hB1, 3'd7, 1'b0, 2'b00, 8'h01, 1'b0};
    vecs[10] = '{8'hB1, 3'd7, 1'b0, 2'b01, 8'hFF, 1'b0};
    vecs[11] = '{8'hB1, 3'd1, 1'b1, 2'b01, 8'h62, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 3'd0, 1'b0, 2'b00);
    repeat (3) @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 12; i++) begin
      single_beat(vecs[i].d, vecs[i].sa, vecs[i].left, vecs[i].mode, res, c, lat);
      check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
`ifdef BARRELSHIFTER_CARRY_OUT_EN
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].expc));
`endif
    end

    // Back-to-back sweep of every amount, direction and mode.
    stalls = 0;
    for (int sa = 0; sa < 8; sa++) begin
      for (int left = 0; left < 2; left++) begin
        for (int mode = 0; mode < 4; mode++) begin
          @(negedge clock);
          drive(8'hB1, 3'(sa), 1'(left), 2'(mode));
          in_valid = 1'b1;
          #1;
          if (!in_ready) stalls++;
        end
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    #3;
    check("sweep_stalls", 32'(stalls), 32'd0);
    check("sweep_drained", 32'(expq.size()), 32'd0);

    // Backpressure: five beats offered against a stalled consumer.
    for (int i = 0; i < 5; i++) begin
      bp_d[i] = 8'(8'hB1 + 8'(i * 37));
      acc_cyc[i] = -1;
    end
    @(negedge clock);
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) @(negedge clock);
      drive(bp_d[idx], 3'(idx + 1), 1'(idx % 2), 2'(idx % 3));
      in_valid = 1'b1;
      #1;
      if (in_ready) idx++;
    end
    @(negedge clock);
    #1;
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_data", 32'(out_data), 32'(ref_out(bp_d[0], 1, 1'b0, 2'b00)));
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6 && idx < 5; cyc++) begin
      if (cyc > 0) begin
        @(negedge clock);
        drive(bp_d[idx], 3'(idx + 1), 1'(idx % 2), 2'(idx % 3));
        #1;
      end else begin
        #1;
      end
      if (in_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
    end
    check("bp_pending0_cycle", 32'(acc_cyc[3]), 32'd0);
    check("bp_pending1_cycle", 32'(acc_cyc[4]), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    #3;
    check("bp_drained", 32'(expq.size()), 32'd0);

    // Random traffic with random consumer stalls.
    n_acc = 0;
    have  = 1'b0;
    for (int cyc = 0; cyc < 3000 && n_acc < 200; cyc++) begin
      @(negedge clock);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have && $urandom_range(0, 4) != 0) begin
        drive(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)));
        have = 1'b1;
      end
      in_valid = have;
      #1;
      if (in_valid && in_ready) begin
        have = 1'b0;
        n_acc++;
      end
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clock);
    #3;
    check("rand_accepts", 32'(n_acc), 32'd200);
    check("rand_drained", 32'(expq.size()), 32'd0);

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(8'(8'h5A + 8'(i)), 3'(i + 1), 1'b1, 2'b00);
      in_valid = 1'b1;
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    #3;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    expq.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
    single_beat(8'hB1, 3'd3, 1'b0, 2'b01, res, c, lat);
    check("post_rst_data", 32'(res), 32'h0000_00F6);
    check("post_rst_latency", 32'(lat), 32'd3);
    repeat (3) @(negedge clock);
    #3;
    check("final_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrelshifter_pipe.md
Name: barrelshifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the 4-bit shifter.
- Generalises WIDTH and shift amount, and adds arithmetic and rotate modes.
- One registered stage per shift-amount bit, with valid/ready handshakes on input and output.
- Sits in the datapath between a producer (ALU operand mux) and a consumer that may stall.

Parameters:
- WIDTH, 16, data width; must be a power of 2 and at least 4.
- SA_W, $clog2(WIDTH), derived localparam: shift-amount width and number of pipeline stages.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_sa  in  SA_W  shift amount, 0..WIDTH-1.
- in_left  in  1  1 = shift/rotate left, 0 = right.
- in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- On reset assertion, immediately:
  - all stage valid bits = 0; out_valid = 0; out_data = 0.
  - stage data, sa, mode and left registers = 0.
- Any beats in flight when reset asserts mid-operation are discarded.
- Pipeline structure: stage k (k = 0..SA_W-1) shifts by 2^k when sa[k] = 1, otherwise passes through.
  - Each stage registers data, sa, left, mode and valid.
  - The last stage's registers drive out_data and out_valid directly.
- Latency: exactly SA_W cycles from the accept edge to out_valid, when out_ready stays high. Throughput is 1 beat per cycle.
- Handshake:
  - stage k advances when !valid_k || advance_{k+1}; the last stage advances when !out_valid || out_ready.
  - in_ready = advance of stage 0. It is combinational from out_ready. No bubbles are inserted.
  - A stalled stage holds all of its registers unchanged.
  - Beats leave in acceptance order; none are dropped or duplicated.
  - out_data stays stable while out_valid && !out_ready.
- Mode rules (n = in_sa):
  - logical: vacated bits are filled with 0.
  - arithmetic right: vacated bits are filled with in_data[WIDTH-1].
  - arithmetic left: identical to logical left.
  - rotate: bits leaving one end enter the other end.
  - 11 (reserved): treated as logical.
- Boundaries:
  - n = 0: out = in in every mode.
  - n = WIDTH-1: logical right leaves only bit 0 = in[WIDTH-1].
  - Simultaneous accept at the input and drain at the output in the same cycle is legal at full occupancy.

Optional Feature:
- Macro: BARRELSHIFTER_CARRY_OUT_EN.
- When defined, add port carry_out (out, 1), pipelined alongside data and reset to 0.
  - Value is the last bit shifted out: in[WIDTH-n] for left, in[n-1] for right.
  - Value is 0 when n = 0.
  - For rotate, carry_out = out_data[0] for left and out_data[WIDTH-1] for right; for n = 0 it is 0.
- When undefined: no carry_out port and no carry logic.

Decomposition:
- Package barrelshifter_pkg:
  - mode constants MODE_LOGIC = 2'b00, MODE_ARITH = 2'b01, MODE_ROT = 2'b10.
  - stage payload struct/typedef (data, sa, left, mode, carry).
- Sub-module barrelshifter_stage, parameterised by SHIFT = 2^k.
  - Contains one stage's shift mux, payload register and valid/advance logic.
  - Instantiated SA_W times in a generate loop.

Test Plan (WIDTH = 8, so latency = 3; in_data = 8'hB1):
- Logical right, sa=3, out_ready=1 -> out_data = 8'h16 three cycles after accept; carry_out = 0.
- Arithmetic right, sa=3 -> out_data = 8'hF6. Then in_data=8'h31, sa=3 -> out_data = 8'h06.
- Rotate left, sa=3 -> 8'h8D. Rotate right, sa=3 -> 8'h36. Logical left, sa=3 -> 8'h88 with carry_out = 1.
- Sweep sa=0..7 for every mode and direction, back-to-back beats -> one result per cycle matching the reference model; sa=0 gives 8'hB1 in every mode.
- Backpressure: out_ready=0 while offering 5 beats -> exactly 3 accepted and in_ready=0; out_data stays stable. Then release out_ready -> results emerge in order and the 2 pending beats are accepted on consecutive cycles.
- Reset mid-stream: assert reset_n=0 with 3 beats in flight -> out_valid and out_data go to 0 immediately without a clock edge. After release, no stale beats appear and the first new beat has latency 3.
